framebuffer_writer: RTL

- Sink for the pixel processor's flushed pixel stream: the receiver end of the `vld`/`rdy` + `color`/`pixel` output interface.
- Converts each fixed-point screen coordinate into a linear framebuffer address.
- Buffers accepted writes in a small FIFO and drains them to a single-port framebuffer write interface with back-pressure.
- Runs a full-screen clear sweep on request.

---
 rtl/framebuffer_writer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/framebuffer_writer.sv
// Pixel-stream sink: fixed-point coord -> linear address, FIFO_DEPTH-entry write queue drained to a single-port framebuffer, plus clear sweep.
// Earliest write one cycle after accept; rdy_in drops when FIFO full or clear pending, mem_* held while mem_rdy low. Optional: FB_BOUNDS_CHECK_EN.
`ifndef COLOR_BITS
`define COLOR_BITS 8
`endif
`ifndef FX_FRAC_BITS
`define FX_FRAC_BITS 4
`endif
`ifndef FX_TOTAL_BITS
`define FX_TOTAL_BITS 16
`endif

package fb_types_pkg;
    typedef struct packed {
        logic [`FX_TOTAL_BITS-1:0] x;
        logic [`FX_TOTAL_BITS-1:0] y;
    } coord_2d_t;
endpackage

module framebuffer_writer
    import fb_types_pkg::*;
#(
    parameter int unsigned            SCREEN_WIDTH  = 320,
    parameter int unsigned            SCREEN_HEIGHT = 240,
    parameter int unsigned            FIFO_DEPTH    = 4,
    parameter int unsigned            ADDR_BITS     = 17,
    parameter logic [`COLOR_BITS-1:0] CLEAR_COLOR   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vld_in,
    input  logic [`COLOR_BITS-1:0] color_in,
    input  coord_2d_t              pixel_in,
    output logic                   rdy_in,
    input  logic                   clear_req,
    output logic                   clear_busy,
    output logic                   clear_done,
    output logic                   mem_we,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [`COLOR_BITS-1:0] mem_wdata,
    input  logic                   mem_rdy,
    output logic [31:0]            written_count
`ifdef FB_BOUNDS_CHECK_EN
    ,
    output logic [15:0]            dropped_count
`endif
);
    localparam int PTR_BITS   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_BITS   = PTR_BITS + 1;
    localparam int COORD_BITS = `FX_TOTAL_BITS - `FX_FRAC_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);
    localparam logic [CNT_BITS-1:0]  FULL_CNT  = CNT_BITS'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_BITS-1:0]   addr;
        logic [`COLOR_BITS-1:0] color;
    } entry_t;

    typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic                   clear_pending_q, clear_pending_d;
    logic                   clear_done_q, clear_done_d;
    logic [ADDR_BITS-1:0]   sweep_q, sweep_d;
    logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]    count_q, count_d;
    entry_t                 fifo_q [FIFO_DEPTH];
    entry_t                 fifo_d [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]   last_addr_q, last_addr_d;
    logic [`COLOR_BITS-1:0] last_wdata_q, last_wdata_d;
    logic [31:0]            written_q, written_d;

    logic [COORD_BITS-1:0]  x_i, y_i;
    logic [ADDR_BITS-1:0]   pix_addr;
    logic                   fifo_full, fifo_empty, accept, in_bounds, push, pop, commit;
    entry_t                 head;
    logic                   unused_frac;

    always_comb begin
        x_i         = pixel_in.x[`FX_TOTAL_BITS-1:`FX_FRAC_BITS];
        y_i         = pixel_in.y[`FX_TOTAL_BITS-1:`FX_FRAC_BITS];
        unused_frac = ^{pixel_in.x[`FX_FRAC_BITS-1:0], pixel_in.y[`FX_FRAC_BITS-1:0]};
        pix_addr    = ADDR_BITS'(32'(y_i) * SCREEN_WIDTH + 32'(x_i));
`ifdef FB_BOUNDS_CHECK_EN
        in_bounds   = (32'(x_i) < SCREEN_WIDTH) && (32'(y_i) < SCREEN_HEIGHT);
`else
        in_bounds   = 1'b1;
`endif
        fifo_full   = (count_q == FULL_CNT);
        fifo_empty  = (count_q == '0);
        head        = fifo_q[rd_ptr_q];
        rdy_in      = (state_q == ST_RUN) && !clear_pending_q && !fifo_full;
        accept      = vld_in && rdy_in;
        push        = accept && in_bounds;
    end

    // Write port: sweep owns it in CLEAR; otherwise FIFO head, or last values when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = last_addr_q;
        mem_wdata = last_wdata_q;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = sweep_q;
            mem_wdata = CLEAR_COLOR;
        end else if (!fifo_empty) begin
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_wdata = head.color;
        end
        commit       = mem_we && mem_rdy;
        pop          = commit && (state_q == ST_RUN);
        last_addr_d  = mem_addr;
        last_wdata_d = mem_wdata;
    end

    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        written_d = written_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{addr: pix_addr, color: color_in};
            wr_ptr_d         = wr_ptr_q + PTR_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_BITS'(1);
            written_d = written_q + 32'd1;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_BITS'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_BITS'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        clear_pending_d = clear_pending_q;
        sweep_d         = sweep_q;
        clear_done_d    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (clear_req && !clear_pending_q) begin
                    clear_pending_d = 1'b1;
                end
                // Queued pixels drain first so the sweep overwrites them.
                if (clear_pending_q && fifo_empty) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end
            end
            ST_CLEAR: begin
                if (mem_rdy) begin
                    if (sweep_q == LAST_ADDR) begin
                        state_d         = ST_RUN;
                        clear_pending_d = 1'b0;
                        clear_done_d    = 1'b1;
                    end else begin
                        sweep_d = sweep_q + ADDR_BITS'(1);
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            clear_pending_q <= 1'b0;
            clear_done_q    <= 1'b0;
            sweep_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            fifo_q          <= '{default: '0};
            last_addr_q     <= '0;
            last_wdata_q    <= '0;
            written_q       <= '0;
        end else begin
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            clear_done_q    <= clear_done_d;
            sweep_q         <= sweep_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            fifo_q          <= fifo_d;
            last_addr_q     <= last_addr_d;
            last_wdata_q    <= last_wdata_d;
            written_q       <= written_d;
        end
    end

    assign clear_busy    = clear_pending_q;
    assign clear_done    = clear_done_q;
    assign written_count = written_q;

`ifdef FB_BOUNDS_CHECK_EN
    logic [15:0] dropped_q, dropped_d;

    always_comb begin
        dropped_d = dropped_q;
        if (accept && !in_bounds && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign dropped_count = dropped_q;
`endif

endmodule
